and_gate: RTL and testbench
===========================

AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter: CNT_W, default 16, width of the high-cycle counter; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all registers.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high; clears all registers.
REQ-004 Port: a  input  1  AND operand 0.
REQ-005 Port: b  input  1  AND operand 1.
REQ-006 Port: c  input  1  AND operand 2.
REQ-007 Port: out  output  1  combinational 3-input AND of a, b, c.
REQ-008 Port: out_q  output  1  out registered on clk.
REQ-009 Port: rise  output  1  one-cycle pulse when out_q goes 0->1.
REQ-010 Port: fall  output  1  one-cycle pulse when out_q goes 1->0.
REQ-011 Port: hi_cnt  output  CNT_W  saturating count of cycles with out_q=1.

Function
REQ-012 out SHALL be purely combinational, with no dependence on clk or rst, and SHALL be valid in the same delta as an input change.
REQ-013 out SHALL follow 4-state AND semantics:
- any input 0 -> 0, regardless of X/Z on the others
- all inputs 1 -> 1
- otherwise -> X
- Z on an input SHALL be treated as X.
REQ-014 On each rising clk edge with rst low, out_q SHALL take the value of out; an X value SHALL be captured as X.
REQ-015 rise SHALL be 1 for exactly one cycle after out_q changes from 0 to 1; transitions involving X SHALL NOT assert rise.
REQ-016 fall SHALL be 1 for exactly one cycle after out_q changes from 1 to 0; transitions involving X SHALL NOT assert fall.
REQ-017 rise and fall SHALL be registered outputs and SHALL never be 1 in the same cycle.
REQ-018 hi_cnt SHALL increment by 1 on each clk edge where out_q==1.
REQ-019 hi_cnt SHALL hold at 2^CNT_W-1 once it reaches that value (saturate, no wrap).
REQ-020 hi_cnt SHALL hold its value when out_q is 0 or X.
REQ-021 Inputs changing between clock edges SHALL affect out immediately and the registered outputs only at the next edge.

Reset
REQ-022 While rst=1, out_q, rise, fall and hi_cnt SHALL be 0 immediately (asynchronously), independent of clk.
REQ-023 out SHALL remain combinational and SHALL be unaffected by rst.
REQ-024 On rst deassertion, the first register update SHALL occur at the next rising clk edge; the previous out_q for edge detection SHALL be taken as 0.
REQ-025 Reset asserted mid-count SHALL clear hi_cnt to 0 and SHALL suppress any pending rise or fall pulse.

Verification
REQ-026 Truth table, out only:
- a=0,b=0,c=0 -> 0
- a=1,b=0,c=0 -> 0
- a=X,b=0,c=0 -> 0
- a=X,b=X,c=X -> X
- a=0,b=1,c=X -> 0
- a=1,b=1,c=1 -> 1
- then a=0,b=0 -> 0
- each step 2 time units apart.
REQ-027 Registered path: rst pulse, then hold a=b=c=1 for 3 edges -> out_q=1 after edge 1, rise=1 only after edge 2 (pulse registered from the 0->1 out_q change), hi_cnt=2 after edge 3.
REQ-028 Fall/X: from out_q=1, drive a=X,b=1,c=1 -> out=X, out_q=X after next edge, fall=0 and rise=0; then drive a=0 -> out_q=0, and no fall pulse is required from X.
REQ-029 Saturation with CNT_W=2: hold all inputs at 1 for 6 edges -> hi_cnt sequence 0,1,2,3,3,3 and never wraps to 0.
REQ-030 Async reset: assert rst between clock edges while hi_cnt=5 and out_q=1 -> out_q, hi_cnt, rise and fall read 0 immediately, while out stays 1.

Source files
------------

// File: rtl/and_gate.sv
// Three-input AND with a registered copy, registered edge pulses on that copy,
// and a saturating count of cycles the registered copy spends high.
module and_gate #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             out,
    output logic             out_q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] hi_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic prev_q_reg;

    // Built-in 4-state AND: a 0 dominates, Z behaves as X.
    assign out = a & b & c;

    // Conditions written as if/else so an X on out_q or prev_q_reg falls to the
    // else branch: no pulse and no count for transitions involving X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= 1'b0;
            prev_q_reg <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            hi_cnt     <= '0;
        end else begin
            out_q      <= out;
            prev_q_reg <= out_q;

            if (out_q == 1'b1 && prev_q_reg == 1'b0)
                rise <= 1'b1;
            else
                rise <= 1'b0;

            if (out_q == 1'b0 && prev_q_reg == 1'b1)
                fall <= 1'b1;
            else
                fall <= 1'b0;

            if (out_q == 1'b1 && hi_cnt != CNT_MAX)
                hi_cnt <= hi_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: directed literal checks plus randomized traffic compared
// every cycle against a history-based reference model (wide and 2-bit counters).
module tb_and_gate;

    logic clk = 1'b0;
    logic rst;
    logic a, b, c;

    logic        out1, out_q1, rise1, fall1;
    logic [15:0] hi1;
    logic        out2, out_q2, rise2, fall2;
    logic [1:0]  hi2;

    int checks = 0;
    int errors = 0;
    logic four_state;
    logic probe;

    and_gate #(.CNT_W(16)) dut_wide (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .out(out1), .out_q(out_q1), .rise(rise1), .fall(fall1), .hi_cnt(hi1)
    );

    and_gate #(.CNT_W(2)) dut_narrow (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .out(out2), .out_q(out_q2), .rise(rise2), .fall(fall2), .hi_cnt(hi2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic and4(input logic x, input logic y, input logic z);
        if (x === 1'b0 || y === 1'b0 || z === 1'b0) return 1'b0;
        if (x === 1'b1 && y === 1'b1 && z === 1'b1) return 1'b1;
        return 1'bx;
    endfunction

    // Reference model: the last three sampled AND results (h0 newest) and
    // an unbounded count of edges that saw a registered 1.
    logic h0, h1, h2;
    int   hcount;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h0 <= 1'b0; h1 <= 1'b0; h2 <= 1'b0;
            hcount <= 0;
        end else begin
            hcount <= hcount + ((h0 === 1'b1) ? 1 : 0);
            h2 <= h1;
            h1 <= h0;
            h0 <= and4(a, b, c);
        end
    end

    always @(negedge clk) begin
        logic exp_rise, exp_fall;
        int   e1, e2;
        exp_rise = (h1 === 1'b1 && h2 === 1'b0);
        exp_fall = (h1 === 1'b0 && h2 === 1'b1);
        e1 = (hcount > 65535) ? 65535 : hcount;
        e2 = (hcount > 3) ? 3 : hcount;
        chk("cyc_out",    {15'd0, out1},   {15'd0, and4(a, b, c)});
        chk("cyc_out_q",  {15'd0, out_q1}, {15'd0, h0});
        chk("cyc_rise",   {15'd0, rise1},  {15'd0, exp_rise});
        chk("cyc_fall",   {15'd0, fall1},  {15'd0, exp_fall});
        chk("cyc_hi",     hi1,             16'(e1));
        chk("cyc_out_q2", {15'd0, out_q2}, {15'd0, h0});
        chk("cyc_rise2",  {15'd0, rise2},  {15'd0, exp_rise});
        chk("cyc_fall2",  {15'd0, fall2},  {15'd0, exp_fall});
        chk("cyc_hi2",    {14'd0, hi2},    16'(e2));
        chk("cyc_excl",   {15'd0, rise1 & fall1}, 16'd0);
    end

    task automatic tt(input logic ta, input logic tb_, input logic tc, input logic ex, input string nm);
        a = ta; b = tb_; c = tc;
        #1;
        if (ex !== 1'bx || four_state) begin
            chk(nm, {15'd0, out1}, {15'd0, ex});
            chk(nm, {15'd0, out2}, {15'd0, ex});
        end
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #3;
    endtask

    initial begin
        a = 1'b0; b = 1'b0; c = 1'b0;
        rst = 1'b1;
        probe = 1'bx;
        four_state = $isunknown(probe);

        edge_step();
        chk("rst_out_q", {15'd0, out_q1}, 16'd0);
        chk("rst_rise",  {15'd0, rise1},  16'd0);
        chk("rst_fall",  {15'd0, fall1},  16'd0);
        chk("rst_hi",    hi1,             16'd0);

        // Truth table run while reset is held: out must ignore rst.
        tt(1'b0, 1'b0, 1'b0, 1'b0, "tt_000");
        tt(1'b1, 1'b0, 1'b0, 1'b0, "tt_100");
        tt(1'bx, 1'b0, 1'b0, 1'b0, "tt_x00");
        tt(1'bx, 1'bx, 1'bx, 1'bx, "tt_xxx");
        tt(1'b0, 1'b1, 1'bx, 1'b0, "tt_01x");
        tt(1'b1, 1'b1, 1'b1, 1'b1, "tt_111");
        tt(1'b0, 1'b0, 1'b1, 1'b0, "tt_001");
        chk("tt_rst_hold_q", {15'd0, out_q1}, 16'd0);

        // Registered path from reset release with all inputs high.
        edge_step();
        rst = 1'b0;
        a = 1'b1; b = 1'b1; c = 1'b1;
        edge_step();
        chk("e1_out_q", {15'd0, out_q1}, 16'd1);
        chk("e1_rise",  {15'd0, rise1},  16'd0);
        chk("e1_hi",    hi1,             16'd0);
        edge_step();
        chk("e2_rise",  {15'd0, rise1},  16'd1);
        chk("e2_hi",    hi1,             16'd1);
        edge_step();
        chk("e3_rise",  {15'd0, rise1},  16'd0);
        chk("e3_hi",    hi1,             16'd2);

        // High-to-X-to-low: no edge pulse at the X step.
        a = 1'bx;
        #1;
        if (four_state) chk("x_out", {15'd0, out1}, {15'd0, 1'bx});
        edge_step();
        if (four_state) chk("x_out_q", {15'd0, out_q1}, {15'd0, 1'bx});
        chk("x_rise", {15'd0, rise1}, 16'd0);
        chk("x_fall", {15'd0, fall1}, 16'd0);
        a = 1'b0;
        edge_step();
        chk("x0_out_q", {15'd0, out_q1}, 16'd0);
        edge_step();
        if (four_state) chk("x0_fall", {15'd0, fall1}, 16'd0);

        // Saturation on the 2-bit counter, then asynchronous reset mid-count.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        a = 1'b1; b = 1'b1; c = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            edge_step();
            chk("sat_hi2", {14'd0, hi2}, 16'((k - 1 > 3) ? 3 : k - 1));
            chk("sat_hi1", hi1, 16'(k - 1));
        end
        chk("pre_ar_out_q", {15'd0, out_q1}, 16'd1);
        rst = 1'b1;
        #1;
        chk("ar_out_q", {15'd0, out_q1}, 16'd0);
        chk("ar_hi",    hi1,             16'd0);
        chk("ar_rise",  {15'd0, rise1},  16'd0);
        chk("ar_fall",  {15'd0, fall1},  16'd0);
        chk("ar_out",   {15'd0, out1},   16'd1);
        edge_step();
        rst = 1'b0;

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 400; n++) begin
            edge_step();
            if ($urandom_range(0, 99) < 3) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            a = ($urandom_range(0, 9) < 8);
            b = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 9) < 8);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
